heap_feeder: RTL and testbench

- Frame-level driver and collector for the streaming top-K heap.
- Accepts candidate records (key + payload) on a valid/ready stream and packs them into the heap's flagged word format (flag 2'b00 = normal).
- Sequences init/en/flush into the heap with the required one-cycle data hold.
- After flush, forwards the retained records (the largest HEAP_SIZE+1 keys) on an output stream. Records the heap evicts during streaming are counted, not forwarded.

---
 rtl/heap_feeder.sv | 188 ++++++++++++++++++
 tb/tb_heap_feeder.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/heap_feeder.sv
// Frame-level driver/collector for the streaming top-K heap: packs candidates, sequences init/en/flush, forwards retained records.
// Latency: accept -> heap_en/heap_din next cycle; heap output -> m_* one registered cycle during DRAIN.
// Backpressure: s_ready drops for EN_GAP cycles after each accept and once frame end is seen; m_* has no backpressure.
module heap_feeder #(
    parameter int DATA_WIDTH   = 32,
    parameter int KEY_WIDTH    = 16,
    parameter int NLEVELS      = 2,
    parameter int EN_GAP       = 1,
    parameter int DRAIN_CYCLES = 2 * ((1 << (NLEVELS + 1)) - 1) + 6
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             frame_start,
    input  logic                             frame_end,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [KEY_WIDTH-1:0]             s_key,
    input  logic [DATA_WIDTH-2-KEY_WIDTH-1:0] s_payload,
    output logic [DATA_WIDTH-1:0]            heap_din,
    output logic                             heap_en,
    output logic                             heap_init,
    output logic                             heap_flush,
    input  logic [DATA_WIDTH-1:0]            heap_dout,
    input  logic                             heap_valid,
    output logic                             m_valid,
    output logic [KEY_WIDTH-1:0]             m_key,
    output logic [DATA_WIDTH-2-KEY_WIDTH-1:0] m_payload,
    output logic                             busy,
    output logic                             done,
    output logic [15:0]                      in_count,
    output logic [15:0]                      evict_count,
    output logic [15:0]                      out_count
);

    localparam int PAY_WIDTH = DATA_WIDTH - 2 - KEY_WIDTH;
    localparam int GAP_W     = $clog2(EN_GAP + 1);
    localparam int DCW       = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_STREAM,
        S_FLUSH,
        S_DRAIN
    } state_t;

    state_t                 state_q;
    logic [GAP_W-1:0]       gap_q;
    logic                   end_pend_q;
    logic [DCW-1:0]         drain_q;
    logic [DATA_WIDTH-1:0]  heap_din_q;
    logic                   heap_en_q;
    logic                   heap_init_q;
    logic                   heap_flush_q;
    logic                   m_valid_q;
    logic [KEY_WIDTH-1:0]   m_key_q;
    logic [PAY_WIDTH-1:0]   m_payload_q;
    logic                   done_q;
    logic [15:0]            in_count_q;
    logic [15:0]            evict_count_q;
    logic [15:0]            out_count_q;

    logic                   accept_d;
    logic                   word_ok_d;

    // Counters stick at all-ones rather than wrapping on very long frames.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Candidates are taken only in STREAM, once the insert gap has elapsed and no frame end is seen.
    always_comb begin
        s_ready   = (state_q == S_STREAM) && (gap_q == '0) && !end_pend_q && !frame_end;
        accept_d  = s_valid && s_ready;
        // The heap only raises valid for normal words; the flag check is a cheap guard against stray markers.
        word_ok_d = heap_valid && (heap_dout[DATA_WIDTH-1:DATA_WIDTH-2] == 2'b00);
    end

    // Frame sequencer: every heap-facing and stream output is a register written here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            gap_q         <= '0;
            end_pend_q    <= 1'b0;
            drain_q       <= '0;
            heap_din_q    <= '0;
            heap_en_q     <= 1'b0;
            heap_init_q   <= 1'b0;
            heap_flush_q  <= 1'b0;
            m_valid_q     <= 1'b0;
            m_key_q       <= '0;
            m_payload_q   <= '0;
            done_q        <= 1'b0;
            in_count_q    <= '0;
            evict_count_q <= '0;
            out_count_q   <= '0;
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            heap_en_q    <= 1'b0;
            heap_init_q  <= 1'b0;
            heap_flush_q <= 1'b0;
            done_q       <= 1'b0;
            m_valid_q    <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (frame_start) begin
                        state_q       <= S_INIT;
                        heap_init_q   <= 1'b1;
                        gap_q         <= '0;
                        end_pend_q    <= 1'b0;
                        in_count_q    <= '0;
                        evict_count_q <= '0;
                        out_count_q   <= '0;
                    end
                end

                S_INIT: begin
                    state_q <= S_STREAM;
                    if (frame_end) begin
                        end_pend_q <= 1'b1;
                    end
                end

                S_STREAM: begin
                    if (accept_d) begin
                        // din is left untouched until the next accept so the heap can sample it a cycle late.
                        heap_din_q <= {2'b00, s_payload, s_key};
                        heap_en_q  <= 1'b1;
                        gap_q      <= GAP_W'(EN_GAP);
                        in_count_q <= sat_inc(in_count_q);
                    end else if (gap_q != '0) begin
                        // Counting every non-insert edge keeps en pulses exactly EN_GAP idle cycles apart.
                        gap_q <= gap_q - 1'b1;
                    end
                    if (frame_end) begin
                        end_pend_q <= 1'b1;
                    end
                    if (word_ok_d) begin
                        evict_count_q <= sat_inc(evict_count_q);
                    end
                    // The last insert has been consumed once its en pulse and gap have both drained.
                    if (end_pend_q && (gap_q == '0) && !heap_en_q) begin
                        state_q      <= S_FLUSH;
                        heap_flush_q <= 1'b1;
                    end
                end

                S_FLUSH: begin
                    drain_q <= '0;
                    state_q <= S_DRAIN;
                end

                S_DRAIN: begin
                    m_valid_q   <= word_ok_d;
                    m_key_q     <= heap_dout[KEY_WIDTH-1:0];
                    m_payload_q <= heap_dout[DATA_WIDTH-3:KEY_WIDTH];
                    if (word_ok_d) begin
                        out_count_q <= sat_inc(out_count_q);
                    end
                    drain_q <= drain_q + 1'b1;
                    if (drain_q == DCW'(DRAIN_CYCLES - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign heap_din    = heap_din_q;
    assign heap_en     = heap_en_q;
    assign heap_init   = heap_init_q;
    assign heap_flush  = heap_flush_q;
    assign m_valid     = m_valid_q;
    assign m_key       = m_key_q;
    assign m_payload   = m_payload_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign in_count    = in_count_q;
    assign evict_count = evict_count_q;
    assign out_count   = out_count_q;

endmodule

// File: tb/tb_heap_feeder.sv
// Bench for heap_feeder: behavioural top-K heap on the heap port, scoreboard of expected records and frame counters.
// Latency: expectations are queued at frame end and popped whenever m_valid or done is seen.
// Backpressure: the driver holds s_valid until s_ready; the output side has none.
module tb_heap_feeder;

    localparam int DW  = 32;
    localparam int KW  = 16;
    localparam int NL  = 2;
    localparam int PW  = DW - 2 - KW;
    localparam int HS  = (1 << (NL + 1)) - 1;
    localparam int CAP = HS + 1;
    localparam int GAP = 1;
    localparam int DC  = 2 * HS + 6;

    logic          clk;
    logic          rstn;
    logic          frame_start;
    logic          frame_end;
    logic          s_valid;
    logic          s_ready;
    logic [KW-1:0] s_key;
    logic [PW-1:0] s_payload;
    logic [DW-1:0] heap_din;
    logic          heap_en;
    logic          heap_init;
    logic          heap_flush;
    logic [DW-1:0] heap_dout;
    logic          heap_valid;
    logic          m_valid;
    logic [KW-1:0] m_key;
    logic [PW-1:0] m_payload;
    logic          busy;
    logic          done;
    logic [15:0]   in_count;
    logic [15:0]   evict_count;
    logic [15:0]   out_count;

    heap_feeder #(
        .DATA_WIDTH(DW), .KEY_WIDTH(KW), .NLEVELS(NL), .EN_GAP(GAP), .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk), .rstn(rstn), .frame_start(frame_start), .frame_end(frame_end),
        .s_valid(s_valid), .s_ready(s_ready), .s_key(s_key), .s_payload(s_payload),
        .heap_din(heap_din), .heap_en(heap_en), .heap_init(heap_init), .heap_flush(heap_flush),
        .heap_dout(heap_dout), .heap_valid(heap_valid),
        .m_valid(m_valid), .m_key(m_key), .m_payload(m_payload),
        .busy(busy), .done(done), .in_count(in_count), .evict_count(evict_count), .out_count(out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [KW-1:0] key;
        logic [PW-1:0] pay;
    } rec_t;

    typedef struct packed {
        logic [15:0] in_c;
        logic [15:0] ev_c;
        logic [15:0] out_c;
    } cnt_t;

    int   tests = 0;
    int   fails = 0;
    rec_t frame_q[$];
    rec_t exp_q[$];
    cnt_t cnt_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural heap: keeps the CAP largest words, evicts the minimum when overfull, drains ascending after flush.
    logic [DW-1:0] hstore[$];
    logic [DW-1:0] hout[$];
    int            hmi;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hstore.delete();
            hout.delete();
            heap_valid <= 1'b0;
            heap_dout  <= '0;
        end else begin
            heap_valid <= 1'b0;
            if (heap_init) begin
                hstore.delete();
                hout.delete();
            end else if (heap_en) begin
                hstore.push_back(heap_din);
                if (hstore.size() > CAP) begin
                    hmi = 0;
                    for (int i = 1; i < hstore.size(); i++)
                        if (hstore[i][KW-1:0] < hstore[hmi][KW-1:0]) hmi = i;
                    heap_valid <= 1'b1;
                    heap_dout  <= hstore[hmi];
                    hstore.delete(hmi);
                end
            end else if (heap_flush) begin
                while (hstore.size() > 0) begin
                    hmi = 0;
                    for (int i = 1; i < hstore.size(); i++)
                        if (hstore[i][KW-1:0] < hstore[hmi][KW-1:0]) hmi = i;
                    hout.push_back(hstore[hmi]);
                    hstore.delete(hmi);
                end
            end else if (hout.size() > 0) begin
                heap_valid <= 1'b1;
                heap_dout  <= hout.pop_front();
            end
        end
    end

    // Reference: the frame's records sorted by key; the top CAP survive in ascending order, the rest are evicted.
    task automatic push_expect();
        rec_t s[$];
        rec_t t;
        int   n;
        int   keep;
        s = frame_q;
        for (int i = 1; i < s.size(); i++)
            for (int j = i; j > 0 && s[j-1].key > s[j].key; j--) begin
                t = s[j]; s[j] = s[j-1]; s[j-1] = t;
            end
        n    = s.size();
        keep = (n < CAP) ? n : CAP;
        for (int i = n - keep; i < n; i++) exp_q.push_back(s[i]);
        cnt_q.push_back('{in_c: 16'(n), ev_c: 16'(n - keep), out_c: 16'(keep)});
    endtask

    // Output monitor: compares each forwarded record and the counters at done.
    logic prev_done = 1'b0;
    rec_t got_e;
    cnt_t got_c;
    always @(negedge clk) begin
        if (rstn) begin
            if (m_valid) begin
                if (exp_q.size() == 0) chk("unexpected_record", {m_key, m_payload}, 0);
                else begin
                    got_e = exp_q.pop_front();
                    chk("m_key", m_key, got_e.key);
                    chk("m_payload", m_payload, got_e.pay);
                end
            end
            if (done) begin
                chk("done_single_pulse", prev_done, 0);
                if (cnt_q.size() == 0) chk("unexpected_done", done, 0);
                else begin
                    got_c = cnt_q.pop_front();
                    chk("in_count", in_count, got_c.in_c);
                    chk("evict_count", evict_count, got_c.ev_c);
                    chk("out_count", out_count, got_c.out_c);
                end
            end
        end
        prev_done = done;
    end

    // Insert-strobe checker: never two en cycles in a row, and din held through the cycle after en.
    logic          prev_en = 1'b0;
    logic [DW-1:0] prev_din = '0;
    always @(negedge clk) begin
        if (!rstn) prev_en = 1'b0;
        else begin
            if (prev_en) begin
                chk("en_back_to_back", heap_en, 0);
                chk("din_hold", heap_din, prev_din);
            end
            prev_en  = heap_en;
            prev_din = heap_din;
        end
    end

    task automatic start_frame();
        @(posedge clk); #1;
        frame_start = 1'b1;
        frame_q.delete();
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic send(input logic [KW-1:0] k, input logic [PW-1:0] p, output int waits);
        s_key     = k;
        s_payload = p;
        s_valid   = 1'b1;
        waits     = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!s_ready && waits < 50);
        if (!s_ready) chk("send_timeout", s_ready, 1);
        else frame_q.push_back('{key: k, pay: p});
        @(posedge clk); #1;
    endtask

    task automatic end_frame();
        s_valid   = 1'b0;
        frame_end = 1'b1;
        @(posedge clk); #1;
        frame_end = 1'b0;
        push_expect();
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!done && c < 300);
        if (!done) chk("done_timeout", done, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_flush();
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!heap_flush && c < 100);
        if (!heap_flush) chk("flush_timeout", heap_flush, 1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_heap_ctl"}, {heap_en, heap_init, heap_flush, done, m_valid, s_ready}, 0);
        chk({nm, "_heap_din"}, heap_din, 0);
        chk({nm, "_m_data"}, {m_key, m_payload}, 0);
        chk({nm, "_counts"}, {in_count, evict_count, out_count}, 0);
    endtask

    function automatic logic [KW-1:0] fresh_key(input rec_t used[$]);
        logic [KW-1:0] k;
        bit            clash;
        do begin
            k     = KW'($urandom);
            clash = 1'b0;
            foreach (used[i]) if (used[i].key == k) clash = 1'b1;
        end while (clash);
        return k;
    endfunction

    initial begin
        int w;
        int c;
        int n;
        logic [KW-1:0] k;
        rstn = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
        s_valid = 1'b0; s_key = '0; s_payload = '0;
        #13;
        chk_all_zero("reset");
        @(posedge clk); #1;
        rstn = 1'b1;

        // Keys 1..10 with s_valid held: two evictions, 3..10 retained, s_ready alternating.
        start_frame();
        for (int i = 1; i <= 10; i++) begin
            send(KW'(i), PW'($urandom), w);
            chk("ready_alternation", w, 2);
        end
        end_frame();
        wait_done();

        // Three records only: nothing evicted, returned sorted.
        start_frame();
        send(16'd5, PW'($urandom), w);
        s_valid = 1'b0;
        @(posedge clk); #1;
        send(16'd2, PW'($urandom), w);
        send(16'd9, PW'($urandom), w);
        end_frame();
        wait_done();

        // frame_end during INIT with no candidates: flush still issued, done after the full drain window.
        frame_q.delete();
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        frame_end   = 1'b1;
        @(posedge clk); #1;
        frame_end = 1'b0;
        push_expect();
        wait_flush();
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!done && c < 100);
        chk("flush_to_done_cycles", c, DC + 1);
        @(posedge clk); #1;

        // frame_start during DRAIN is ignored.
        start_frame();
        for (int i = 0; i < 3; i++) send(fresh_key(frame_q), PW'($urandom), w);
        end_frame();
        wait_flush();
        repeat (3) @(posedge clk);
        #1 frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        @(negedge clk);
        chk("busy_in_drain", busy, 1);
        chk("in_count_in_drain", in_count, 3);
        wait_done();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_restart", {busy, heap_init}, 0);
        end

        // Reset mid-STREAM after four inserts, then a clean two-record frame.
        start_frame();
        for (int i = 0; i < 4; i++) send(KW'(20 + i), PW'($urandom), w);
        s_valid = 1'b0;
        #2 rstn = 1'b0;
        #1 chk_all_zero("midreset");
        frame_q.delete();
        @(negedge clk);
        @(posedge clk); #1;
        rstn = 1'b1;
        start_frame();
        send(16'd7, PW'($urandom), w);
        send(16'd8, PW'($urandom), w);
        end_frame();
        wait_done();

        // Random frames with distinct keys and random idle gaps.
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(0, 14);
            start_frame();
            for (int i = 0; i < n; i++) begin
                k = fresh_key(frame_q);
                send(k, PW'($urandom), w);
                if ($urandom_range(0, 2) == 0) begin
                    s_valid = 1'b0;
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
            end_frame();
            wait_done();
        end

        repeat (4) @(posedge clk);
        #1;
        chk("records_left", exp_q.size(), 0);
        chk("counts_left", cnt_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
